ascon_ctrl: RTL
===============

ASCON_CTRL -- requirements
Module: ascon_ctrl

Interface
REQ-001 SHALL have parameter BLOCK_AW, default 4, meaning the width of the AD and message block counters (up to 2^BLOCK_AW-1 blocks per phase).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start_i, input, 1, a start request, sampled only in IDLE.
REQ-005 SHALL have port decrypt_i, input, 1, the mode, captured at start and driven on decrypt_o.
REQ-006 SHALL have port ad_blocks_i, input, BLOCK_AW, the AD block count A, captured at start.
REQ-007 SHALL have port msg_blocks_i, input, BLOCK_AW, the padded message block count N, captured at start; N=0 is treated as 1.
REQ-008 SHALL have ports di_valid_i (input, 1) and di_ready_o (output, 1), the 128-bit input block handshake.
REQ-009 SHALL have ports do_valid_o (output, 1) and do_ready_i (input, 1), the output block handshake.
REQ-010 SHALL have outputs op_o (4), round_o (4), blk_no_o (BLOCK_AW), decrypt_o (1), state_we_o (1), tag_valid_o (1), busy_o (1) and done_o (1), which drive the round function and the state register.

Function
REQ-011 SHALL implement the FSM states IDLE, INIT, AD, MSG and FINAL; exactly one permutation round is executed per enabled cycle.
REQ-012 IDLE: when start_i=1, SHALL capture A, N and decrypt and go to INIT with round counter 0; busy_o=0 only in IDLE.
REQ-013 INIT (12 cycles): round_o=0..11; op=1 on round 0; op=2 on round 11 if A>0, op=3 if A=0; otherwise op=0; SHALL then go to AD if A>0, else MSG.
REQ-014 AD (8 cycles per block): round_o=4..11; op=4 on round 4 (consumes input); op=5 on round 11 of block A-1; else op=0; blk_no_o=AD block index; SHALL go to MSG after the last block.
REQ-015 MSG blocks 0..N-2 (8 cycles each): round_o=4..11; op=6 on round 4 (consumes input, produces output); else op=0.
REQ-016 FINAL (12 cycles): round_o=0..11; op=7 on round 0 (consumes message block N-1, produces output); op=8 on round 11; tag_valid_o=1 for that single cycle; SHALL then return to IDLE with done_o pulsed for one cycle.
REQ-017 On op 4 cycles: di_ready_o=1; the cycle advances only if di_valid_i=1.
REQ-018 On op 6/7 cycles: do_valid_o=di_valid_i and di_ready_o=do_ready_i; the cycle advances only when di_valid_i and do_ready_i are both 1.
REQ-019 While stalled, the FSM SHALL hold op_o, round_o and blk_no_o, drive state_we_o=0 and keep counters unchanged; on all other non-IDLE cycles state_we_o=1.
REQ-020 In IDLE: op_o=0, state_we_o=0, di_ready_o=0, do_valid_o=0 and tag_valid_o=0.
REQ-021 start_i while busy SHALL be ignored; input changes after start SHALL have no effect.
REQ-022 Unstalled latency from start to done SHALL be 24 + 8*A + 8*(N-1) cycles.
REQ-023 Counter wrap: block indices SHALL compare against the captured count and never exceed count-1.

Reset
REQ-024 rst_i=1 SHALL asynchronously force IDLE, clear all counters and captured values, and drive every output to 0; this applies mid-operation, and no done_o or tag_valid_o pulse is produced for the aborted operation.
REQ-025 After rst_i deasserts, the first start_i SHALL be accepted in the next clock cycle.

Verification
REQ-026 A=0, N=1, inputs always valid/ready -> op sequence 1, 0x10, 3, 7, 0x10, 8; done_o asserted 24 cycles after start; tag_valid_o asserted one cycle before done_o.
REQ-027 A=2, N=3 -> op 2 at INIT end; ops 4 and 5 in the correct rounds; blk_no_o 0,1 then 0,1; done_o asserted 56 cycles after start.
REQ-028 di_valid_i=0 for 5 cycles at the first op 4 -> state_we_o=0 and outputs frozen during the stall; done_o delayed by exactly 5 cycles.
REQ-029 do_ready_i=0 during op 7 -> di_ready_o=0 and no advance; do_valid_o follows di_valid_i.
REQ-030 rst_i asserted during AD round 7 -> all outputs 0 immediately; no done_o; a fresh start then runs the normal sequence.
REQ-031 start_i held high during the whole operation -> exactly one operation runs, then a new one starts the cycle after done_o.

Source files
------------

// File: rtl/ascon_ctrl_if.sv
`timescale 1ns/1ps
// Block handshake between the ASCON controller and the surrounding data path.
// Signal suffixes are from the controller's point of view.
interface ascon_ctrl_if;
    logic di_valid_i;
    logic di_ready_o;
    logic do_valid_o;
    logic do_ready_i;

    modport master (
        output di_valid_i,
        output do_ready_i,
        input  di_ready_o,
        input  do_valid_o
    );

    modport slave (
        input  di_valid_i,
        input  do_ready_i,
        output di_ready_o,
        output do_valid_o
    );
endinterface

// File: rtl/ascon_ctrl.sv
`timescale 1ns/1ps
// ASCON AEAD sequencing controller: walks INIT, AD, MSG and FINAL phases one
// permutation round per enabled cycle and tells the datapath what to do.
module ascon_ctrl #(
    parameter int BLOCK_AW = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                decrypt_i,
    input  logic [BLOCK_AW-1:0] ad_blocks_i,
    input  logic [BLOCK_AW-1:0] msg_blocks_i,
    ascon_ctrl_if.slave         hs,
    output logic [3:0]          op_o,
    output logic [3:0]          round_o,
    output logic [BLOCK_AW-1:0] blk_no_o,
    output logic                decrypt_o,
    output logic                state_we_o,
    output logic                tag_valid_o,
    output logic                busy_o,
    output logic                done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_AD,
        S_MSG,
        S_FINAL
    } state_t;

    localparam logic [3:0] OP_NONE      = 4'd0;
    localparam logic [3:0] OP_INIT_KEY  = 4'd1;
    localparam logic [3:0] OP_INIT_AD   = 4'd2;
    localparam logic [3:0] OP_INIT_NOAD = 4'd3;
    localparam logic [3:0] OP_AD_ABS    = 4'd4;
    localparam logic [3:0] OP_AD_SEP    = 4'd5;
    localparam logic [3:0] OP_MSG       = 4'd6;
    localparam logic [3:0] OP_MSG_LAST  = 4'd7;
    localparam logic [3:0] OP_TAG       = 4'd8;

    state_t              state_q, state_d;
    logic [3:0]          round_q, round_d;
    logic [BLOCK_AW-1:0] blk_q, blk_d;
    logic [BLOCK_AW-1:0] a_q, a_d;
    logic [BLOCK_AW-1:0] n_q, n_d;
    logic                dec_q, dec_d;
    logic                done_q, done_d;

    logic [3:0]          op;
    logic                advance;
    logic                di_ready;
    logic                do_valid;
    logic                last_ad;
    logic                last_msg;
    logic                has_ad;
    logic                multi_msg;

    assign has_ad    = (a_q != '0);
    assign multi_msg = (n_q > BLOCK_AW'(1));
    // Only meaningful inside AD (A>0) and MSG (N>1), so no underflow there.
    assign last_ad   = (blk_q == a_q - BLOCK_AW'(1));
    assign last_msg  = (blk_q == n_q - BLOCK_AW'(2));

    always_comb begin
        op       = OP_NONE;
        advance  = 1'b1;
        di_ready = 1'b0;
        do_valid = 1'b0;
        state_d  = state_q;
        round_d  = round_q;
        blk_d    = blk_q;
        a_d      = a_q;
        n_d      = n_q;
        dec_d    = dec_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_INIT: begin
                if (round_q == 4'd0)       op = OP_INIT_KEY;
                else if (round_q == 4'd11) op = has_ad ? OP_INIT_AD : OP_INIT_NOAD;
            end
            S_AD: begin
                if (round_q == 4'd4)                 op = OP_AD_ABS;
                else if (round_q == 4'd11 && last_ad) op = OP_AD_SEP;
            end
            S_MSG: begin
                if (round_q == 4'd4) op = OP_MSG;
            end
            S_FINAL: begin
                if (round_q == 4'd0)       op = OP_MSG_LAST;
                else if (round_q == 4'd11) op = OP_TAG;
            end
            default: op = OP_NONE;
        endcase

        // Input-consuming rounds wait for data; output-producing ones also wait for the sink.
        if (op == OP_AD_ABS) begin
            di_ready = 1'b1;
            advance  = hs.di_valid_i;
        end else if (op == OP_MSG || op == OP_MSG_LAST) begin
            do_valid = hs.di_valid_i;
            di_ready = hs.do_ready_i;
            advance  = hs.di_valid_i & hs.do_ready_i;
        end

        if (state_q == S_IDLE) begin
            if (start_i) begin
                a_d     = ad_blocks_i;
                n_d     = (msg_blocks_i == '0) ? BLOCK_AW'(1) : msg_blocks_i;
                dec_d   = decrypt_i;
                round_d = 4'd0;
                blk_d   = '0;
                state_d = S_INIT;
            end
        end else if (advance) begin
            round_d = round_q + 4'd1;
            if (round_q == 4'd11) begin
                unique case (state_q)
                    S_INIT: begin
                        blk_d = '0;
                        if (has_ad) begin
                            state_d = S_AD;
                            round_d = 4'd4;
                        end else if (multi_msg) begin
                            state_d = S_MSG;
                            round_d = 4'd4;
                        end else begin
                            state_d = S_FINAL;
                            round_d = 4'd0;
                        end
                    end
                    S_AD: begin
                        if (last_ad) begin
                            blk_d   = '0;
                            state_d = multi_msg ? S_MSG : S_FINAL;
                            round_d = multi_msg ? 4'd4 : 4'd0;
                        end else begin
                            blk_d   = blk_q + BLOCK_AW'(1);
                            round_d = 4'd4;
                        end
                    end
                    S_MSG: begin
                        // Leaving the last full block lands blk on N-1 for FINAL.
                        blk_d   = blk_q + BLOCK_AW'(1);
                        state_d = last_msg ? S_FINAL : S_MSG;
                        round_d = last_msg ? 4'd0 : 4'd4;
                    end
                    S_FINAL: begin
                        state_d = S_IDLE;
                        round_d = 4'd0;
                        done_d  = 1'b1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            round_q <= '0;
            blk_q   <= '0;
            a_q     <= '0;
            n_q     <= '0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            blk_q   <= blk_d;
            a_q     <= a_d;
            n_q     <= n_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign state_we_o    = busy_o & advance;
    assign op_o          = op;
    assign round_o       = busy_o ? round_q : 4'd0;
    assign blk_no_o      = busy_o ? blk_q : '0;
    assign decrypt_o     = dec_q;
    assign tag_valid_o   = (op == OP_TAG);
    assign done_o        = done_q;
    assign hs.di_ready_o = di_ready;
    assign hs.do_valid_o = do_valid;

endmodule
